// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtract sequencer.
//   Computes Y = A - B (mod 2^WIDTH) and borrow = (A < B) with a single
//   1-bit subtract cell. Bits are processed LSB first, one per enabled clock.
// Ports:
//   clk, rst_n     rising-edge clock, async active-low reset
//   en             global enable; 0 freezes all state
//   start, A, B    operand request, accepted when start & ready & en
//   ready          high in IDLE
//   busy           high in SHIFT
//   done           high for the one DONE cycle (extended while stalled)
//   Y, borrow      last completed result, held until the next completion

module serial_sub_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bw,
  output logic o_d,
  output logic o_bw
);
  assign o_d  = i_a ^ i_b ^ i_bw;
  assign o_bw = (~i_a & i_b) | (~(i_a ^ i_b) & i_bw);
endmodule

module serial_sub_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             borrow
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_sa, r_sb, r_sr, r_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bw, r_borrow;
  logic             w_d, w_bw, w_last;

  serial_sub_cell u_cell (
    .i_a (r_sa[0]),
    .i_b (r_sb[0]),
    .i_bw(r_bw),
    .o_d (w_d),
    .o_bw(w_bw)
  );

  // Last bit is being consumed on this edge.
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r_state <= S_IDLE;
    else if (en) r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:              w_next = S_IDLE;
      default:             w_next = S_IDLE;
    endcase
  end

  // Datapath: operand/result shifters, borrow chain, counter, result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_bw     <= 1'b0;
      r_cnt    <= '0;
      r_y      <= '0;
      r_borrow <= 1'b0;
    end else if (en) begin
      case (r_state)
        S_IDLE: if (start) begin
          r_sa  <= A;
          r_sb  <= B;
          r_bw  <= 1'b0;
          r_cnt <= '0;
        end
        S_SHIFT: begin
          r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
          r_sr  <= {w_d, r_sr[WIDTH-1:1]};
          r_bw  <= w_bw;
          r_cnt <= r_cnt + CNT_W'(1);
          // Capture includes the bit produced on this same edge.
          if (w_last) begin
            r_y      <= {w_d, r_sr[WIDTH-1:1]};
            r_borrow <= w_bw;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    ready = (r_state == S_IDLE);
    busy  = (r_state == S_SHIFT);
    done  = (r_state == S_DONE);
  end

  assign Y      = r_y;
  assign borrow = r_borrow;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic       start8 = 1'b0, start2 = 1'b0;
  logic [7:0] A8 = '0, B8 = '0;
  logic [1:0] A2 = '0, B2 = '0;
  logic       ready8, busy8, done8, borrow8;
  logic [7:0] Y8;
  logic       ready2, busy2, done2, borrow2;
  logic [1:0] Y2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start8), .A(A8), .B(B8),
    .ready(ready8), .busy(busy8), .done(done8), .Y(Y8), .borrow(borrow8));

  serial_sub_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start2), .A(A2), .B(B2),
    .ready(ready2), .busy(busy2), .done(done2), .Y(Y2), .borrow(borrow2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: index 0 = 8-bit unit, 1 = 2-bit unit.
  // rem = enabled edges left until the result appears; the result itself is
  // plain modular arithmetic computed at acceptance.
  int          m_rem [2] = '{0, 0};
  logic        m_done[2] = '{1'b0, 1'b0};
  logic [31:0] m_y   [2] = '{0, 0};
  logic        m_b   [2] = '{1'b0, 1'b0};
  logic [31:0] m_p   [2] = '{0, 0};
  logic        m_pb  [2] = '{1'b0, 1'b0};
  logic [31:0] ia[2], ib[2];
  logic        st[2];

  always_comb begin
    ia[0] = {24'd0, A8}; ib[0] = {24'd0, B8}; st[0] = start8;
    ia[1] = {30'd0, A2}; ib[1] = {30'd0, B2}; st[1] = start2;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_rem[k] <= 0; m_done[k] <= 1'b0; m_y[k] <= '0; m_b[k] <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < 2; k++) begin
        if (m_done[k]) m_done[k] <= 1'b0;
        else if (m_rem[k] > 0) begin
          m_rem[k] <= m_rem[k] - 1;
          if (m_rem[k] == 1) begin
            m_done[k] <= 1'b1; m_y[k] <= m_p[k]; m_b[k] <= m_pb[k];
          end
        end else if (st[k]) begin
          m_rem[k] <= (k == 0) ? 8 : 2;
          m_p[k]   <= (ia[k] - ib[k]) & ((k == 0) ? 32'hFF : 32'h3);
          m_pb[k]  <= (ia[k] < ib[k]);
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("ready8",  ready8,  (m_rem[0] == 0 && !m_done[0]));
    chk("busy8",   busy8,   (m_rem[0] > 0));
    chk("done8",   done8,   m_done[0]);
    chk("Y8",      Y8,      m_y[0]);
    chk("borrow8", borrow8, m_b[0]);
    chk("ready2",  ready2,  (m_rem[1] == 0 && !m_done[1]));
    chk("busy2",   busy2,   (m_rem[1] > 0));
    chk("done2",   done2,   m_done[1]);
    chk("Y2",      Y2,      m_y[1]);
    chk("borrow2", borrow2, m_b[1]);
  end

  // One 8-bit operation with literal expectations. n counts negedges after the
  // accepting edge; negedge n sits between edges n-1 and n.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int stall_at,
                     input int stall_len, input bit inject, input logic [7:0] ey,
                     input logic eb, input string nm);
    int n;
    n = 0;
    while (!ready8 && n < 40) begin @(negedge clk); n++; end
    chk({nm, "_idle"}, ready8, 1);
    @(posedge clk); #1; A8 = a; B8 = b; start8 = 1'b1; en = 1'b1;
    @(posedge clk); #1; start8 = 1'b0; A8 = 8'($urandom); B8 = 8'($urandom);
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk); n++;
      if (inject && n == 3) begin start8 = 1'b1; A8 = 8'hFF; B8 = 8'h00; end
      if (inject && n == 4) start8 = 1'b0;
      if (stall_len > 0 && n == stall_at) en = 1'b0;
      if (stall_len > 0 && n == stall_at + stall_len) en = 1'b1;
    end
    chk({nm, "_latency"}, n, 9 + stall_len);
    chk({nm, "_Y"}, Y8, ey);
    chk({nm, "_borrow"}, borrow8, eb);
    chk({nm, "_model_Y"}, m_y[0], {24'd0, ey});
    chk({nm, "_ready_in_done"}, ready8, 0);
    @(negedge clk);
    chk({nm, "_ready_after"}, ready8, 1);
    chk({nm, "_done_pulse"}, done8, 0);
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b);
    int n;
    logic [1:0] ey;
    ey = a - b;
    n = 0;
    while (!ready2 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1; A2 = a; B2 = b; start2 = 1'b1; en = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    n = 0;
    while (!done2 && n < 20) begin @(negedge clk); n++; end
    chk("w2_latency", n, 3);
    chk("w2_Y", Y2, ey);
    chk("w2_borrow", borrow2, (a < b));
  endtask

  initial begin
    int n;
    bit saw_done;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_Y", Y8, 0);
    chk("rst_borrow", borrow8, 0);
    rst_n = 1'b1; en = 1'b1;

    op8(8'h5A, 8'h3C, 0, 0, 1'b0, 8'h1E, 1'b0, "T1");
    op8(8'h00, 8'h01, 0, 0, 1'b0, 8'hFF, 1'b1, "T2a");
    op8(8'hA5, 8'hA5, 0, 0, 1'b0, 8'h00, 1'b0, "T2b");
    op8(8'h80, 8'h7F, 4, 3, 1'b0, 8'h01, 1'b0, "T3");
    op8(8'h33, 8'h11, 0, 0, 1'b1, 8'h22, 1'b0, "T4");

    // T5: reset after four bits of 0x0F - 0xF0.
    @(posedge clk); #1; A8 = 8'h0F; B8 = 8'hF0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (5) @(negedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("T5_ready", ready8, 1);
    chk("T5_busy", busy8, 0);
    chk("T5_done", done8, 0);
    chk("T5_Y", Y8, 0);
    chk("T5_borrow", borrow8, 0);
    repeat (2) @(negedge clk);
    #2; rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) saw_done = 1'b1;
    end
    chk("T5_no_done", saw_done, 0);
    chk("T5_Y_after", Y8, 0);

    // T6: exhaustive 2-bit.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        op2(2'(a), 2'(b));

    // Random traffic on both units, including stalls and ignored starts.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      en     = ($urandom_range(0, 7) != 0);
      start8 = ($urandom_range(0, 2) == 0);
      start2 = ($urandom_range(0, 1) == 0);
      A8 = 8'($urandom); B8 = 8'($urandom);
      A2 = 2'($urandom); B2 = 2'($urandom);
    end
    @(posedge clk); #1; en = 1'b1; start8 = 1'b0; start2 = 1'b0;
    n = 0;
    while (!(ready8 && ready2) && n < 30) begin @(negedge clk); n++; end
    chk("drain_idle", (ready8 && ready2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
